// File: rtl/io_ports.sv
// Bidirectional parallel I/O ports with per-bit direction, input
// synchronisers and edge-triggered interrupt flags.
module io_ports #(
  parameter int NPORTS      = 2,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0,
  localparam int AW         = $clog2(NPORTS) + 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     we_n,
  input  logic [AW-1:0]            A,
  input  logic [7:0]               DI,
  output logic [7:0]               DO,
  output logic                     OE,
  output logic [NPORTS*WIDTH-1:0]  PO,
  output logic [NPORTS*WIDTH-1:0]  POE,
  input  logic [NPORTS*WIDTH-1:0]  PI,
  output logic                     irq_n
);

  localparam int NB = NPORTS * WIDTH;

  logic [WIDTH-1:0] data_q [NPORTS];
  logic [WIDTH-1:0] ddr_q  [NPORTS];
  logic [WIDTH-1:0] ien_q  [NPORTS];
  logic [WIDTH-1:0] ifr_q  [NPORTS];

  logic [NB-1:0] sync_q [SYNC_STAGES];
  logic [NB-1:0] hist_q;
  logic [NB-1:0] pin;
  logic [NB-1:0] edg;

  logic [AW-1:0]     pfield;
  logic [1:0]        r;
  logic [NPORTS-1:0] sel;
  logic              valid;
  logic              wr;
  logic              rd;
  logic [WIDTH-1:0]  wdata;
  logic [7:0]        rdata;
  logic              pend;

  assign pfield = A >> 2;
  assign r      = A[1:0];
  assign wdata  = DI[WIDTH-1:0];
  assign pin    = sync_q[SYNC_STAGES-1];

  always_comb begin
    case (EDGE_MODE)
      0:       edg = pin & ~hist_q;
      1:       edg = ~pin & hist_q;
      default: edg = pin ^ hist_q;
    endcase
  end

  // Port index beyond NPORTS selects nothing, so the access is inert.
  always_comb begin
    sel   = '0;
    rdata = 8'h00;
    pend  = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      sel[p] = enable && (pfield == AW'(p));
      pend   = pend | (|(ifr_q[p] & ien_q[p]));
      if (sel[p]) begin
        unique case (r)
          2'd0: rdata = 8'((ddr_q[p] & data_q[p]) |
                           (~ddr_q[p] & pin[p*WIDTH +: WIDTH]));
          2'd1: rdata = 8'(ddr_q[p]);
          2'd2: rdata = 8'(ien_q[p]);
          2'd3: rdata = 8'(ifr_q[p]);
        endcase
      end
    end
    valid = |sel;
    wr    = valid && !we_n;
    rd    = valid && we_n;
  end

  always_comb begin
    PO  = '0;
    POE = '0;
    for (int p = 0; p < NPORTS; p++) begin
      PO[p*WIDTH +: WIDTH]  = data_q[p];
      POE[p*WIDTH +: WIDTH] = ddr_q[p];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < NPORTS; p++) begin
        data_q[p] <= '0;
        ddr_q[p]  <= '0;
        ien_q[p]  <= '0;
        ifr_q[p]  <= '0;
      end
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q <= '0;
      DO     <= 8'h00;
      OE     <= 1'b0;
      irq_n  <= 1'b1;
    end else begin
      sync_q[0] <= PI;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= pin;
      OE     <= rd;
      DO     <= rd ? rdata : 8'h00;
      irq_n  <= !pend;
      for (int p = 0; p < NPORTS; p++) begin
        if (wr && sel[p] && r == 2'd0) data_q[p] <= wdata;
        if (wr && sel[p] && r == 2'd1) ddr_q[p]  <= wdata;
        if (wr && sel[p] && r == 2'd2) ien_q[p]  <= wdata;
        // A new edge wins over a same-cycle write-1-to-clear.
        ifr_q[p] <= (ifr_q[p] &
                     ~((wr && sel[p] && r == 2'd3) ? wdata : '0)) |
                    (edg[p*WIDTH +: WIDTH] & ~ddr_q[p] & ien_q[p]);
      end
    end
  end

endmodule

// File: tb/tb_io_ports.sv
// Self-checking bench for io_ports: directed scenarios plus random
// traffic compared every cycle against a cycle-level reference model.
module tb_io_ports;

  localparam int NP = 3;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam int EM = 0;
  localparam int AW = $clog2(NP) + 2;
  localparam int NB = NP * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          we_n = 1'b1;
  logic [AW-1:0] A = '0;
  logic [7:0]    DI = 8'h00;
  logic [7:0]    DO;
  logic          OE;
  logic [NB-1:0] PO;
  logic [NB-1:0] POE;
  logic [NB-1:0] PI = '0;
  logic          irq_n;

  always #5 clk = ~clk;

  io_ports #(
    .NPORTS(NP), .WIDTH(W), .SYNC_STAGES(SS), .EDGE_MODE(EM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .we_n(we_n),
    .A(A), .DI(DI), .DO(DO), .OE(OE),
    .PO(PO), .POE(POE), .PI(PI), .irq_n(irq_n)
  );

  int compared = 0;
  int mismatched = 0;

  logic [W-1:0]  m_data [NP];
  logic [W-1:0]  m_ddr  [NP];
  logic [W-1:0]  m_ien  [NP];
  logic [W-1:0]  m_ifr  [NP];
  logic [7:0]    m_do = 8'h00;
  logic          m_oe = 1'b0;
  logic          m_irq = 1'b1;
  // pad samples taken at past edges, newest first
  logic [NB-1:0] samp [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] edges(logic [NB-1:0] cur,
                                          logic [NB-1:0] prev);
    case (EM)
      0:       return cur & ~prev;
      1:       return ~cur & prev;
      default: return cur ^ prev;
    endcase
  endfunction

  task automatic model_clear();
    for (int p = 0; p < NP; p++) begin
      m_data[p] = '0; m_ddr[p] = '0; m_ien[p] = '0; m_ifr[p] = '0;
    end
    samp.delete();
    for (int i = 0; i <= SS; i++) samp.push_back('0);
  endtask

  task automatic tick();
    logic [NB-1:0] pin_v, ev, pi_v, pexp, oexp;
    logic [W-1:0]  clr, set;
    logic [7:0]    rdv, di_v;
    int            p, r;
    logic          valid, any, en_v, we_v, rst_v;
    pin_v = samp[SS-1];
    ev    = edges(samp[SS-1], samp[SS]);
    p     = int'(A >> 2);
    r     = int'(A[1:0]);
    en_v  = enable; we_v = we_n; di_v = DI; pi_v = PI; rst_v = rst_n;
    valid = en_v && p < NP;
    rdv   = 8'h00;
    any   = 1'b0;
    for (int q = 0; q < NP; q++) any = any | (|(m_ifr[q] & m_ien[q]));
    if (valid) begin
      case (r)
        0: rdv = (m_ddr[p] & m_data[p]) | (~m_ddr[p] & pin_v[p*W +: W]);
        1: rdv = m_ddr[p];
        2: rdv = m_ien[p];
        default: rdv = m_ifr[p];
      endcase
    end
    @(posedge clk);
    if (!rst_v) begin
      model_clear();
      m_oe = 1'b0; m_do = 8'h00; m_irq = 1'b1;
    end else begin
      m_oe  = valid && we_v;
      m_do  = (valid && we_v) ? rdv : 8'h00;
      m_irq = !any;
      for (int q = 0; q < NP; q++) begin
        set = ev[q*W +: W] & ~m_ddr[q] & m_ien[q];
        clr = (valid && !we_v && p == q && r == 3) ? di_v : '0;
        m_ifr[q] = (m_ifr[q] & ~clr) | set;
        if (valid && !we_v && p == q) begin
          if (r == 0) m_data[q] = di_v;
          if (r == 1) m_ddr[q]  = di_v;
          if (r == 2) m_ien[q]  = di_v;
        end
      end
      samp.push_front(pi_v);
      void'(samp.pop_back());
    end
    #1;
    for (int q = 0; q < NP; q++) begin
      pexp[q*W +: W] = m_data[q];
      oexp[q*W +: W] = m_ddr[q];
    end
    chk("oe", 32'(OE), 32'(m_oe));
    chk("do", 32'(DO), 32'(m_do));
    chk("irq_n", 32'(irq_n), 32'(m_irq));
    chk("po", 32'(PO), 32'(pexp));
    chk("poe", 32'(POE), 32'(oexp));
  endtask

  task automatic wr(int p, int r, logic [7:0] d);
    enable = 1'b1; we_n = 1'b0; A = AW'((p << 2) | r); DI = d;
    tick();
    enable = 1'b0; we_n = 1'b1;
  endtask

  task automatic rd(int p, int r);
    enable = 1'b1; we_n = 1'b1; A = AW'((p << 2) | r);
    tick();
    enable = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0;
    idle(2);
    chk("rst_irq_n", 32'(irq_n), 32'h1);
    chk("rst_po", 32'(PO), 32'h0);
    PI = 24'hFF_FF_FF;
    rst_n = 1'b1;
    idle(4);
    rd(0, 3);
    chk("no_flag_at_release", 32'(DO), 32'h0);
    PI = '0;
    idle(4);

    // mixed direction read-back
    wr(0, 1, 8'hF0);
    wr(0, 0, 8'hA5);
    PI[7:0] = 8'h0C;
    idle(3);
    rd(0, 0);
    chk("mixed_do", 32'(DO), 32'hAC);
    chk("mixed_oe", 32'(OE), 32'h1);

    // rising edge -> flag -> irq, then clear
    wr(1, 2, 8'h01);
    PI[8] = 1'b1;
    idle(3);
    chk("irq_before", 32'(irq_n), 32'h1);
    rd(1, 3);
    chk("ifr_set", 32'(DO), 32'h01);
    chk("irq_asserted", 32'(irq_n), 32'h0);
    wr(1, 3, 8'h01);
    tick();
    chk("irq_released", 32'(irq_n), 32'h1);

    // edge lands on the same cycle as the clear
    PI[8] = 1'b0;
    idle(3);
    PI[8] = 1'b1;
    idle(3);
    PI[8] = 1'b0;
    idle(3);
    PI[8] = 1'b1;
    idle(2);
    wr(1, 3, 8'h01);
    rd(1, 3);
    chk("set_beats_clear", 32'(DO), 32'h01);
    chk("irq_held", 32'(irq_n), 32'h0);
    wr(1, 3, 8'h01);
    idle(2);

    // output bits never flag
    wr(0, 1, 8'h01);
    wr(0, 2, 8'h01);
    PI[0] = 1'b1;
    idle(4);
    PI[0] = 1'b0;
    idle(4);
    rd(0, 3);
    chk("ddr_masks_flag", 32'(DO), 32'h00);
    chk("ddr_irq_n", 32'(irq_n), 32'h1);

    // nonexistent port is inert
    wr(3, 0, 8'hFF);
    wr(3, 1, 8'hFF);
    rd(3, 0);
    chk("bad_port_oe", 32'(OE), 32'h0);
    chk("bad_port_do", 32'(DO), 32'h00);
    rd(0, 1);
    chk("bad_port_ddr", 32'(DO), 32'h01);

    // reset with a pending interrupt
    PI[8] = 1'b0;
    idle(3);
    PI[8] = 1'b1;
    idle(4);
    chk("pre_rst_irq", 32'(irq_n), 32'h0);
    rst_n = 1'b0;
    enable = 1'b1; we_n = 1'b0; A = AW'(1); DI = 8'hFF;
    tick();
    enable = 1'b0; we_n = 1'b1;
    rst_n = 1'b1;
    chk("rst_irq", 32'(irq_n), 32'h1);
    chk("rst_po2", 32'(PO), 32'h0);
    chk("rst_poe2", 32'(POE), 32'h0);
    rd(1, 3);
    chk("rst_ifr", 32'(DO), 32'h00);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      enable = 1'($urandom_range(0, 1));
      we_n   = 1'($urandom_range(0, 1));
      A      = AW'($urandom);
      DI     = 8'($urandom);
      PI     = PI ^ (NB'($urandom) & NB'($urandom) & NB'($urandom));
      rst_n  = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1;
    enable = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
